// File: rtl/tspp_types_pkg.sv
// Shared types for the TSPP memory-side responder: bus word, FSM state encoding
// and the default read-back pattern for out-of-range accesses.
package tspp_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_WAIT,
    RSP_DONE
  } rsp_state_t;

  localparam word_t RSP_BAD_DATA = 32'hBAD1BAD1;

  // Wait-state counter width; a zero-latency responder still carries a 1-bit counter.
  function automatic int rsp_cnt_width(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/tspp_byte_ram.sv
// DEPTH x 32 synchronous RAM with four independent byte-lane write enables
// and a registered read port.
module tspp_byte_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Lane-masked write and registered read; contents are never cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tspp_mem_responder.sv
// Slave end of the TSPP generic bus: captures one request at a time, inserts
// LATENCY wait states, then completes it with a one-cycle busy==0 window.
// A request that changes or disappears while waiting is dropped with abort_err.
module tspp_mem_responder
  import tspp_types_pkg::*;
#(
  parameter int    DEPTH    = 1024,
  parameter int    LATENCY  = 2,
  parameter word_t BAD_DATA = RSP_BAD_DATA
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        ren,
  input  logic        wen,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        range_err,
  output logic        abort_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = rsp_cnt_width(LATENCY);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  rsp_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      cap_addr;
  logic [31:0]      cap_wdata;
  logic [3:0]       cap_be;
  logic             cap_write;
  logic             cap_range;
  logic             abort_q;
  word_t            rdata_q;
  word_t            ram_q;
  word_t            done_data;
  logic [3:0]       ram_we;
  logic [AW-1:0]    ram_raddr;
  logic             req;
  logic             req_range;
  logic             capture;
  logic             abort_hit;

  // A simultaneous ren/wen is a write; anything at or above 4*DEPTH is out of range.
  assign req       = ren | wen;
  assign req_range = (addr >> (AW + 2)) != 32'd0;
  assign capture   = (state == RSP_IDLE) && req;
  assign abort_hit = (state == RSP_WAIT) &&
                     (!req || (addr != cap_addr) || (wen != cap_write));

  // Read the incoming address while idle so a zero-latency read has data in DONE.
  assign ram_raddr = (state == RSP_IDLE) ? addr[AW+1:2] : cap_addr[AW+1:2];
  assign done_data = cap_write ? 32'd0 : (cap_range ? BAD_DATA : ram_q);

  tspp_byte_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .waddr (cap_addr[AW+1:2]),
    .wdata (cap_wdata),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= RSP_IDLE;
    else     state <= state_nxt;
  end

  // Next state: IDLE -> WAIT (or straight to DONE) -> DONE -> IDLE, abort back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      RSP_IDLE: if (req) state_nxt = (LATENCY == 0) ? RSP_DONE : RSP_WAIT;
      RSP_WAIT: begin
        if (abort_hit)            state_nxt = RSP_IDLE;
        else if (cnt == CNT_LAST) state_nxt = RSP_DONE;
      end
      RSP_DONE: state_nxt = RSP_IDLE;
      default:  state_nxt = RSP_IDLE;
    endcase
  end

  // Outputs: DONE is the only cycle that drops busy, reports range and commits writes.
  always_comb begin
    busy      = 1'b1;
    range_err = 1'b0;
    rdata     = rdata_q;
    ram_we    = 4'b0000;
    if (state == RSP_DONE) begin
      busy      = 1'b0;
      range_err = cap_range;
      rdata     = done_data;
      if (cap_write && !cap_range) ram_we = cap_be;
    end
  end

  // Wait-state counter loads on capture and counts down through WAIT.
  always_ff @(posedge CLK) begin
    if (RST)                    cnt <= '0;
    else if (capture)           cnt <= CNT_INIT;
    else if (state == RSP_WAIT) cnt <= cnt - 1'b1;
  end

  // Request fields latched at capture; held steady until the next capture.
  always_ff @(posedge CLK) begin
    if (capture) begin
      cap_addr  <= addr;
      cap_wdata <= wdata;
      cap_be    <= byte_en;
      cap_write <= wen;
      cap_range <= req_range;
    end
  end

  // Completion data is held after DONE; abort pulse lasts the cycle after detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_q <= '0;
      abort_q <= 1'b0;
    end else begin
      if (state == RSP_DONE) rdata_q <= done_data;
      abort_q <= abort_hit;
    end
  end

  assign abort_err = abort_q;

endmodule

// File: tb/tb_tspp_mem_responder.sv
// Scoreboard bench for tspp_mem_responder: directed scenarios plus randomized
// traffic against a word-array memory model; a separate zero-latency instance
// checks back-to-back throughput.
module tb_tspp_mem_responder;

  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam logic [31:0] BAD   = 32'hBAD1BAD1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        ren, wen, busy, range_err, abort_err;
  logic [3:0]  byte_en;

  logic [31:0] addr0, wdata0, rdata0;
  logic        ren0, wen0, busy0, range_err0, abort_err0;
  logic [3:0]  byte_en0;

  always #5 clk = ~clk;

  tspp_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .BAD_DATA(BAD)) u_dut (
    .CLK(clk), .RST(rst), .addr(addr), .wdata(wdata), .ren(ren), .wen(wen),
    .byte_en(byte_en), .rdata(rdata), .busy(busy), .range_err(range_err),
    .abort_err(abort_err)
  );

  tspp_mem_responder #(.DEPTH(DEPTH), .LATENCY(0), .BAD_DATA(BAD)) u_dut0 (
    .CLK(clk), .RST(rst), .addr(addr0), .wdata(wdata0), .ren(ren0), .wen(wen0),
    .byte_en(byte_en0), .rdata(rdata0), .busy(busy0), .range_err(range_err0),
    .abort_err(abort_err0)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        rerr;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl [DEPTH];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          exp_abort = 0;
  int          obs_abort = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: word array indexed by byte address / 4, writes merged per enabled lane.
  task automatic model_push(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] be, input int due);
    exp_t e;
    logic rng;
    int   idx;
    rng    = (a >= 32'(4 * DEPTH));
    idx    = int'(a / 4) % DEPTH;
    e.due  = due;
    e.rerr = rng;
    if (w) begin
      e.rdata = 32'd0;
      if (!rng) begin
        for (int i = 0; i < 4; i++) if (be[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
      end
    end else begin
      e.rdata = rng ? BAD : mdl[idx];
    end
    if (r || w) sbq.push_back(e);
  endtask

  // Monitor: every busy==0 cycle must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (abort_err === 1'b1) obs_abort++;
      if (busy === 1'b0) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_done: busy=0 with nothing pending (cyc %0d)", cyc);
        end else begin : pop_blk
          exp_t e;
          e = sbq.pop_front();
          chk("rdata", rdata, e.rdata);
          chk("range_err", {31'd0, range_err}, {31'd0, e.rerr});
          chk("done_cycle", cyc, e.due);
        end
      end else if (range_err !== 1'b0) begin
        total++; bad++;
        $display("FAIL range_err_busy: range_err=%b while busy=%b", range_err, busy);
      end
    end
  end

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    if (k == 40) begin
      total++; bad++;
      $display("FAIL %s_timeout: busy=%b expected 0 within 40 cycles", name, busy);
    end
  endtask

  // Called on a negedge; b2b means the previous access is in its DONE cycle right now.
  task automatic issue(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input bit b2b,
                       input string name);
    ren = r; wen = w; addr = a; wdata = d; byte_en = be;
    model_push(r, w, a, d, be, cyc + 1 + LAT + (b2b ? 1 : 0));
    wait_done(name);
  endtask

  task automatic gap(input int n);
    ren = 1'b0; wen = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Request held for one cycle only, then withdrawn: no completion, one abort pulse.
  task automatic issue_abort(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be);
    ren = r; wen = w; addr = a; wdata = d; byte_en = be;
    @(negedge clk);
    ren = 1'b0; wen = 1'b0;
    exp_abort++;
    repeat (2) @(negedge clk);
  endtask

  function automatic int idx_of(input int k);
    return (k < 16) ? k : DEPTH - 1;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          pending_b2b;
    int          k;
    logic        r, w;
    logic [31:0] a;

    rst = 1'b1;
    ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; byte_en = '0;
    ren0 = 1'b0; wen0 = 1'b0; addr0 = '0; wdata0 = '0; byte_en0 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset then idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_range_err", {31'd0, range_err}, 32'd0);
      chk("rst_abort_err", {31'd0, abort_err}, 32'd0);
      chk("rst_busy0", {31'd0, busy0}, 32'd1);
    end

    // Give every word used later a known value.
    for (int i = 0; i < 17; i++) begin
      issue(1'b0, 1'b1, 32'(idx_of(i) * 4), $urandom, 4'hF, 1'b0, "init");
      gap(1);
    end

    // Full write/read, then byte-lane merge.
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "wr10"); gap(1);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, "rd10");        gap(1);
    issue(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0, "wr10_lanes"); gap(1);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, "rd10_lanes");  gap(1);

    // Out of range: read, write (aliases word 0 in the index bits), re-read word 0.
    issue(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, "rd_oor");    gap(1);
    issue(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b0, "wr_oor"); gap(1);
    issue(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, "rd0_after_oor"); gap(1);
    issue(1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 1'b0, "rd_top_oor"); gap(1);
    issue(1'b1, 1'b0, 32'hFFC, 32'h0, 4'h0, 1'b0, "rd_last_word"); gap(1);

    // ren+wen is a write; empty byte mask leaves the word alone.
    issue(1'b1, 1'b1, 32'h14, 32'hA5A5_5A5A, 4'hF, 1'b0, "rw_both"); gap(1);
    issue(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0, "rd_both");     gap(1);
    issue(1'b0, 1'b1, 32'h18, 32'h1234_5678, 4'h0, 1'b0, "wr_be0"); gap(1);
    issue(1'b1, 1'b0, 32'h18, 32'h0, 4'h0, 1'b0, "rd_be0");      gap(1);

    // Abort by withdrawal (write then read), and by address change while waiting.
    issue_abort(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    issue(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, "rd20_after_abort"); gap(1);
    issue_abort(1'b1, 1'b0, 32'h24, 32'h0, 4'h0);
    ren = 1'b1; addr = 32'h0;
    @(negedge clk);
    addr = 32'h4;
    exp_abort++;
    model_push(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, cyc + 2 + LAT);
    wait_done("addr_change");
    gap(1);

    // Reset in the middle of a write drops it.
    wen = 1'b1; addr = 32'h20; wdata = 32'h0BADF00D; byte_en = 4'hF;
    @(negedge clk);
    rst = 1'b1; wen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, "rd20_after_rst"); gap(1);

    // Randomized traffic with occasional back-to-back holds and aborts.
    pending_b2b = 1'b0;
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 9);
      r = (k < 5) || (k == 9);
      w = (k >= 5);
      if ($urandom_range(0, 6) == 0) begin
        a = $urandom;
        if (a < 32'h1000) a = a + 32'h1000;
      end else begin
        a = 32'(idx_of($urandom_range(0, 16)) * 4) + 32'($urandom_range(0, 3));
      end
      if (!pending_b2b && ($urandom_range(0, 9) == 0)) begin
        issue_abort(r, w, a, $urandom, 4'($urandom));
        continue;
      end
      issue(r, w, a, $urandom, 4'($urandom), pending_b2b, "rand");
      if ($urandom_range(0, 3) == 0) begin
        pending_b2b = 1'b1;
      end else begin
        pending_b2b = 1'b0;
        gap($urandom_range(1, 2));
      end
    end
    gap(2);

    // Zero-latency instance: writes complete one cycle after being seen.
    for (int j = 0; j < 2; j++) begin
      wen0 = 1'b1; addr0 = 32'(j * 4); wdata0 = (j == 0) ? 32'h11111111 : 32'h22222222;
      byte_en0 = 4'hF;
      for (k = 1; k < 10; k++) begin
        @(negedge clk);
        if (busy0 === 1'b0) break;
      end
      chk("lat0_wr_latency", 32'(k), 32'd1);
      wen0 = 1'b0;
      @(negedge clk);
    end

    // Reads held continuously, address flipped after each completion.
    ren0 = 1'b1; addr0 = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("lat0_busy", {31'd0, busy0}, (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i % 2 == 0) begin
        chk("lat0_rdata", rdata0, ((i / 2) % 2 == 0) ? 32'h11111111 : 32'h22222222);
        addr0 = (addr0 == 32'h0) ? 32'h4 : 32'h0;
      end
    end
    ren0 = 1'b0;
    repeat (2) @(negedge clk);

    chk("abort_count", 32'(obs_abort), 32'(exp_abort));
    chk("pending_left", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
